// File: rtl/line_serializer.sv
// Serializes one packed line of PIXELS pixels into a one-pixel-per-beat stream, pixel 0 (MSB end) first.
// Optional feature: define LINE_SER_LAST_EN to add the registered pixel_last output.
module line_serializer #(
    parameter int PIXEL_W = 24,
    parameter int PIXELS  = 3,
    parameter int LINE_W  = PIXEL_W * PIXELS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line,
    input  logic               line_valid,
    output logic               line_ready,
    output logic [PIXEL_W-1:0] pixel,
    output logic               pixel_valid,
    input  logic               pixel_ready
`ifdef LINE_SER_LAST_EN
    ,
    output logic               pixel_last
`endif
);

    localparam int IDX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

    typedef enum logic [0:0] {
        IDLE,
        EMIT
    } state_t;

    state_t            state, state_next;
    logic [LINE_W-1:0] hold, hold_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              pixel_xfer;
    logic              line_take;
    logic              at_last;

    assign pixel_valid = (state == EMIT);
    assign pixel       = hold[LINE_W-1 -: PIXEL_W];
    assign pixel_xfer  = pixel_valid & pixel_ready;
    assign at_last     = (idx == LAST_IDX);
    assign line_ready  = !rst & (!pixel_valid | (pixel_xfer & at_last));
    assign line_take   = line_valid & line_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new line may only replace the hold register on the final-pixel transfer, which keeps the
    // stream gap-free without ever dropping a pixel still owed to the consumer.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (line_take) begin
                    hold_next  = line;
                    idx_next   = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (line_take) begin
                    hold_next  = line;
                    idx_next   = '0;
                end else if (pixel_xfer) begin
                    hold_next = hold << PIXEL_W;
                    if (at_last) begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            idx  <= '0;
        end else begin
            hold <= hold_next;
            idx  <= idx_next;
        end
    end

`ifdef LINE_SER_LAST_EN
    // Registered from next-state values so it lines up exactly with the pixel it tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_last <= 1'b0;
        end else begin
            pixel_last <= (state_next == EMIT) && (idx_next == LAST_IDX);
        end
    end
`endif

endmodule

// File: tb/tb_line_serializer.sv
// Directed self-checking bench for line_serializer (PIXEL_W=24, PIXELS=3); checks pixel_last when LINE_SER_LAST_EN is defined.
module tb_line_serializer;

    logic        clk;
    logic        rst;
    logic [71:0] line;
    logic        line_valid;
    logic        line_ready;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic        pixel_ready;
`ifdef LINE_SER_LAST_EN
    logic        pixel_last;
`endif

    int checks;
    int errors;

    localparam logic [71:0] L1 = 72'h111111_222222_333333;
    localparam logic [71:0] LA = 72'hAAAAAA_BBBBBB_CCCCCC;
    localparam logic [71:0] LB = 72'h010203_040506_070809;
    localparam logic [71:0] LD = 72'hABCDEF_123456_FEDCBA;
    localparam logic [71:0] LE = 72'h0F0F0F_F0F0F0_5A5A5A;
    localparam logic [71:0] L4 = 72'h444444_555555_666666;
    localparam logic [71:0] LX = 72'hDEADBE_EF0123_456789;

    line_serializer #(
        .PIXEL_W(24),
        .PIXELS (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line       (line),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready)
`ifdef LINE_SER_LAST_EN
        ,
        .pixel_last (pixel_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [71:0] ln, input logic pr);
        rst         = r;
        line_valid  = lv;
        line        = ln;
        pixel_ready = pr;
        #1;
    endtask

    // Drive one cycle's inputs, check the outputs visible during that cycle, then advance one clock.
    task automatic runCycle(input string tag, input logic r, input logic lv, input logic [71:0] ln,
                            input logic pr, input logic ev, input logic [23:0] ep,
                            input logic elr, input logic el);
        applyStimulus(r, lv, ln, pr);
        checkOutput({tag, ".valid"}, 72'(pixel_valid), 72'(ev));
        checkOutput({tag, ".ready"}, 72'(line_ready), 72'(elr));
        if (ev) checkOutput({tag, ".pixel"}, 72'(pixel), 72'(ep));
`ifdef LINE_SER_LAST_EN
        checkOutput({tag, ".last"}, 72'(pixel_last), 72'(el));
`else
        if (el && !ev) $display("[TB] note: %s expects last without valid", tag);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // reset values; line_ready must be held low while rst is high
        runCycle("rst0", 1, 1, L1, 1, 0, 24'h000000, 0, 0);
        checkOutput("rst.pixel", 72'(pixel), 72'h0);

        // single line, consumer always ready
        runCycle("t1c0", 0, 1, L1, 1, 0, 24'h0, 1, 0);
        runCycle("t1c1", 0, 0, L1, 1, 1, 24'h111111, 0, 0);
        runCycle("t1c2", 0, 0, L1, 1, 1, 24'h222222, 0, 0);
        runCycle("t1c3", 0, 0, L1, 1, 1, 24'h333333, 1, 1);
        runCycle("t1c4", 0, 0, L1, 1, 0, 24'h0, 1, 0);

        // two back-to-back lines with no bubble
        runCycle("t2c0", 0, 1, LA, 1, 0, 24'h0, 1, 0);
        runCycle("t2c1", 0, 1, LB, 1, 1, 24'hAAAAAA, 0, 0);
        runCycle("t2c2", 0, 1, LB, 1, 1, 24'hBBBBBB, 0, 0);
        runCycle("t2c3", 0, 1, LB, 1, 1, 24'hCCCCCC, 1, 1);
        runCycle("t2c4", 0, 0, LB, 1, 1, 24'h010203, 0, 0);
        runCycle("t2c5", 0, 0, LB, 1, 1, 24'h040506, 0, 0);
        runCycle("t2c6", 0, 0, LB, 1, 1, 24'h070809, 1, 1);
        runCycle("t2c7", 0, 0, LB, 1, 0, 24'h0, 1, 0);

        // back-pressure on emission clocks 2 and 3
        runCycle("t3c0", 0, 1, L1, 1, 0, 24'h0, 1, 0);
        runCycle("t3c1", 0, 0, L1, 1, 1, 24'h111111, 0, 0);
        runCycle("t3c2", 0, 0, L1, 0, 1, 24'h222222, 0, 0);
        runCycle("t3c3", 0, 0, L1, 0, 1, 24'h222222, 0, 0);
        runCycle("t3c4", 0, 0, L1, 1, 1, 24'h222222, 0, 0);
        runCycle("t3c5", 0, 0, L1, 1, 1, 24'h333333, 1, 1);
        runCycle("t3c6", 0, 0, L1, 1, 0, 24'h0, 1, 0);

        // a waiting line is refused while stalled mid-line, then taken on the final pixel
        runCycle("t4c0", 0, 1, LD, 1, 0, 24'h0, 1, 0);
        runCycle("t4c1", 0, 1, LE, 0, 1, 24'hABCDEF, 0, 0);
        runCycle("t4c2", 0, 1, LE, 0, 1, 24'hABCDEF, 0, 0);
        runCycle("t4c3", 0, 1, LE, 0, 1, 24'hABCDEF, 0, 0);
        runCycle("t4c4", 0, 1, LE, 1, 1, 24'hABCDEF, 0, 0);
        runCycle("t4c5", 0, 1, LE, 1, 1, 24'h123456, 0, 0);
        runCycle("t4c6", 0, 1, LE, 1, 1, 24'hFEDCBA, 1, 1);
        runCycle("t4c7", 0, 0, LE, 1, 1, 24'h0F0F0F, 0, 0);
        runCycle("t4c8", 0, 0, LE, 1, 1, 24'hF0F0F0, 0, 0);
        runCycle("t4c9", 0, 0, LE, 1, 1, 24'h5A5A5A, 1, 1);
        runCycle("t4c10", 0, 0, LE, 1, 0, 24'h0, 1, 0);

        // the final pixel is stalled while a line waits: nothing is taken until pixel_ready returns
        runCycle("t6c0", 0, 1, L1, 1, 0, 24'h0, 1, 0);
        runCycle("t6c1", 0, 0, L1, 1, 1, 24'h111111, 0, 0);
        runCycle("t6c2", 0, 0, L1, 1, 1, 24'h222222, 0, 0);
        runCycle("t6c3", 0, 1, LX, 0, 1, 24'h333333, 0, 1);
        runCycle("t6c4", 0, 1, LX, 1, 1, 24'h333333, 1, 1);
        runCycle("t6c5", 0, 0, LX, 1, 1, 24'hDEADBE, 0, 0);
        runCycle("t6c6", 0, 0, LX, 1, 1, 24'hEF0123, 0, 0);
        runCycle("t6c7", 0, 0, LX, 1, 1, 24'h456789, 1, 1);
        runCycle("t6c8", 0, 0, LX, 1, 0, 24'h0, 1, 0);

        // reset mid-line discards the remainder
        runCycle("t5c0", 0, 1, L1, 1, 0, 24'h0, 1, 0);
        runCycle("t5c1", 0, 0, L1, 1, 1, 24'h111111, 0, 0);
        runCycle("t5c2", 1, 0, L1, 1, 1, 24'h222222, 0, 0);
        checkOutput("t5.rst.pixel", 72'(pixel), 72'h0);
        runCycle("t5c3", 1, 1, L4, 1, 0, 24'h0, 0, 0);
        runCycle("t5c4", 0, 1, L4, 1, 0, 24'h0, 1, 0);
        runCycle("t5c5", 0, 0, L4, 1, 1, 24'h444444, 0, 0);
        runCycle("t5c6", 0, 0, L4, 1, 1, 24'h555555, 0, 0);
        runCycle("t5c7", 0, 0, L4, 1, 1, 24'h666666, 1, 1);
        runCycle("t5c8", 0, 0, L4, 1, 0, 24'h0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
